// File: rtl/seg_port_arbiter_if.sv
// Request/response bundle for one requester of the segment-register arbiter.
// The requester side uses the master modport, the arbiter uses slave.
interface seg_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  sel;
  logic [15:0] wdata;
  logic        ack;
  logic        rvalid;
  logic [15:0] rdata;

  modport master (output req, wr, sel, wdata, input ack, rvalid, rdata);
  modport slave  (input req, wr, sel, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/seg_port_arbiter.sv
// Two-port arbiter in front of the segment register file: A has priority,
// B is protected from starvation, A may lock the bus across a sequence.
module seg_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_port_arbiter_if.slave    a_port,
  seg_port_arbiter_if.slave    b_port,
  input  logic                 a_lock,
  output logic [1:0]           rf_rd_sel,
  output logic                 rf_wr_en,
  output logic [1:0]           rf_wr_sel,
  output logic [15:0]          rf_wr_val,
  input  logic [15:0]          rf_rd_val,
  output logic                 cs_written
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] SEL_CS = 2'd1;

  logic [3:0]  starve_cnt_r;
  logic        lock_own_r;
  logic        hz_valid_r;
  logic [1:0]  hz_sel_r;
  logic [1:0]  rd_sel_r;
  logic        a_pend_r;
  logic        b_pend_r;
  logic [15:0] a_hold_r;
  logic [15:0] b_hold_r;
  logic        cs_pend_r;

  logic        a_ok_s;
  logic        b_ok_s;
  logic        lock_block_s;
  logic        force_b_s;
  logic        a_grant_s;
  logic        b_grant_s;
  logic        g_wr_s;
  logic [1:0]  g_sel_s;
  logic [15:0] g_wdata_s;
  logic        rd_grant_s;
  logic        wr_grant_s;

  // Arbitration: a write to the select read last cycle is held off, lock keeps B out.
  always_comb begin
    a_grant_s    = 1'b0;
    b_grant_s    = 1'b0;
    a_ok_s       = a_port.req && !(a_port.wr && hz_valid_r && (a_port.sel == hz_sel_r));
    b_ok_s       = b_port.req && !(b_port.wr && hz_valid_r && (b_port.sel == hz_sel_r));
    lock_block_s = a_lock && (lock_own_r || a_port.req);
    force_b_s    = b_port.req && (starve_cnt_r == LIMIT) && !lock_block_s;
    if (reset) begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end else if (force_b_s && b_ok_s) begin
      b_grant_s = 1'b1;
    end else if (a_ok_s) begin
      a_grant_s = 1'b1;
    end else if (b_ok_s && !lock_block_s) begin
      b_grant_s = 1'b1;
    end else begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end
  end

  // Route the winning request onto the register-file side.
  always_comb begin
    g_wr_s    = 1'b0;
    g_sel_s   = 2'd0;
    g_wdata_s = 16'h0000;
    if (a_grant_s) begin
      g_wr_s    = a_port.wr;
      g_sel_s   = a_port.sel;
      g_wdata_s = a_port.wdata;
    end else if (b_grant_s) begin
      g_wr_s    = b_port.wr;
      g_sel_s   = b_port.sel;
      g_wdata_s = b_port.wdata;
    end else begin
      g_wr_s    = 1'b0;
      g_sel_s   = 2'd0;
      g_wdata_s = 16'h0000;
    end
    rd_grant_s = (a_grant_s || b_grant_s) && !g_wr_s;
    wr_grant_s = (a_grant_s || b_grant_s) && g_wr_s;
  end

  assign a_port.ack    = a_grant_s;
  assign b_port.ack    = b_grant_s;
  assign rf_wr_en      = wr_grant_s;
  assign rf_wr_sel     = wr_grant_s ? g_sel_s : 2'd0;
  assign rf_wr_val     = wr_grant_s ? g_wdata_s : 16'h0000;
  assign rf_rd_sel     = reset ? 2'd0 : (rd_grant_s ? g_sel_s : rd_sel_r);
  // Read data arrives straight from the register file in the rvalid cycle.
  assign a_port.rvalid = a_pend_r && !reset;
  assign b_port.rvalid = b_pend_r && !reset;
  assign a_port.rdata  = reset ? 16'h0000 : (a_pend_r ? rf_rd_val : a_hold_r);
  assign b_port.rdata  = reset ? 16'h0000 : (b_pend_r ? rf_rd_val : b_hold_r);
  assign cs_written    = cs_pend_r && !reset;

  // Starvation, lock, hazard and read-return state.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
      lock_own_r   <= 1'b0;
      hz_valid_r   <= 1'b0;
      hz_sel_r     <= 2'd0;
      rd_sel_r     <= 2'd0;
      a_pend_r     <= 1'b0;
      b_pend_r     <= 1'b0;
      a_hold_r     <= 16'h0000;
      b_hold_r     <= 16'h0000;
      cs_pend_r    <= 1'b0;
    end else begin
      if (!b_port.req || b_grant_s) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r < LIMIT) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
      lock_own_r <= a_lock && (a_grant_s || lock_own_r);
      hz_valid_r <= rd_grant_s;
      if (rd_grant_s) begin
        hz_sel_r <= g_sel_s;
        rd_sel_r <= g_sel_s;
      end
      a_pend_r <= a_grant_s && !g_wr_s;
      b_pend_r <= b_grant_s && !g_wr_s;
      if (a_pend_r) begin
        a_hold_r <= rf_rd_val;
      end
      if (b_pend_r) begin
        b_hold_r <= rf_rd_val;
      end
      cs_pend_r <= wr_grant_s && (g_sel_s == SEL_CS);
    end
  end

endmodule

// File: tb/tb_seg_port_arbiter.sv
// Directed bench for seg_port_arbiter: a rule-level model is compared on every
// negative edge, and literal expectations pin the key scenarios.
module tb_seg_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_lock;
  logic [1:0]  rf_rd_sel;
  logic        rf_wr_en;
  logic [1:0]  rf_wr_sel;
  logic [15:0] rf_wr_val;
  logic [15:0] rf_rd_val;
  logic        cs_written;

  int checks = 0;
  int errors = 0;

  seg_port_arbiter_if a_if();
  seg_port_arbiter_if b_if();

  seg_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .a_port(a_if), .b_port(b_if), .a_lock(a_lock),
    .rf_rd_sel(rf_rd_sel), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .rf_wr_val(rf_wr_val), .rf_rd_val(rf_rd_val), .cs_written(cs_written)
  );

  always #5 clk = ~clk;

  // Register file environment: one-cycle read latency with same-cycle write bypass.
  logic [15:0] rf_mem [4];
  always @(posedge clk) begin
    if (rf_wr_en) rf_mem[rf_wr_sel] <= rf_wr_val;
    rf_rd_val <= (rf_wr_en && rf_wr_sel == rf_rd_sel) ? rf_wr_val : rf_mem[rf_rd_sel];
  end

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int          m_wait;
  bit          m_lock;
  bit          m_hz;
  logic [1:0]  m_hz_sel;
  int          m_pend;
  logic [15:0] m_pend_data;
  logic [15:0] m_hold_a;
  logic [15:0] m_hold_b;
  logic [1:0]  m_rd_sel;
  bit          m_cs;
  logic [15:0] m_seg [4];
  bit          m_a_ok, m_b_ok, m_blk, m_any, m_wr;
  int          m_gr;
  logic [1:0]  m_sel;
  logic [15:0] m_wd;

  always @(negedge clk) begin
    if (reset) begin
      chk1("rst_a_ack", a_if.ack, 1'b0);
      chk1("rst_b_ack", b_if.ack, 1'b0);
      chk1("rst_a_rvalid", a_if.rvalid, 1'b0);
      chk1("rst_b_rvalid", b_if.rvalid, 1'b0);
      chk16("rst_a_rdata", a_if.rdata, 16'h0000);
      chk16("rst_b_rdata", b_if.rdata, 16'h0000);
      chk1("rst_wr_en", rf_wr_en, 1'b0);
      chk16("rst_rd_sel", {14'd0, rf_rd_sel}, 16'h0000);
      chk1("rst_cs_written", cs_written, 1'b0);
      m_wait = 0; m_lock = 1'b0; m_hz = 1'b0; m_pend = 0;
      m_hold_a = 16'h0000; m_hold_b = 16'h0000; m_rd_sel = 2'd0; m_cs = 1'b0;
    end else begin
      m_a_ok = a_if.req && !(a_if.wr && m_hz && a_if.sel == m_hz_sel);
      m_b_ok = b_if.req && !(b_if.wr && m_hz && b_if.sel == m_hz_sel);
      m_blk  = a_lock && (m_lock || a_if.req);
      if (b_if.req && m_wait == LIMIT && !m_blk && m_b_ok) m_gr = 2;
      else if (m_a_ok) m_gr = 1;
      else if (m_b_ok && !m_blk) m_gr = 2;
      else m_gr = 0;
      if (m_gr == 1) begin
        m_wr = a_if.wr; m_sel = a_if.sel; m_wd = a_if.wdata;
      end else begin
        m_wr = b_if.wr; m_sel = b_if.sel; m_wd = b_if.wdata;
      end
      m_any = (m_gr != 0);

      chk1("a_ack", a_if.ack, m_gr == 1);
      chk1("b_ack", b_if.ack, m_gr == 2);
      chk1("wr_en", rf_wr_en, m_any && m_wr);
      chk16("wr_sel", {14'd0, rf_wr_sel}, (m_any && m_wr) ? {14'd0, m_sel} : 16'h0000);
      chk16("wr_val", rf_wr_val, (m_any && m_wr) ? m_wd : 16'h0000);
      chk16("rd_sel", {14'd0, rf_rd_sel}, {14'd0, (m_any && !m_wr) ? m_sel : m_rd_sel});
      chk1("a_rvalid", a_if.rvalid, m_pend == 1);
      chk1("b_rvalid", b_if.rvalid, m_pend == 2);
      chk16("a_rdata", a_if.rdata, (m_pend == 1) ? m_pend_data : m_hold_a);
      chk16("b_rdata", b_if.rdata, (m_pend == 2) ? m_pend_data : m_hold_b);
      chk1("cs_written", cs_written, m_cs);

      if (m_pend == 1) m_hold_a = m_pend_data;
      if (m_pend == 2) m_hold_b = m_pend_data;
      m_pend      = (m_any && !m_wr) ? m_gr : 0;
      m_pend_data = m_seg[m_sel];
      if (m_any && m_wr) m_seg[m_sel] = m_wd;
      m_cs     = m_any && m_wr && (m_sel == 2'd1);
      m_hz     = m_any && !m_wr;
      m_hz_sel = m_sel;
      if (m_any && !m_wr) m_rd_sel = m_sel;
      m_lock = a_lock && (m_lock || m_gr == 1);
      if (!b_if.req || m_gr == 2) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic req, logic wr, logic [1:0] sel, logic [15:0] wd);
    a_if.req = req; a_if.wr = wr; a_if.sel = sel; a_if.wdata = wd;
  endtask

  task automatic drive_b(logic req, logic wr, logic [1:0] sel, logic [15:0] wd);
    b_if.req = req; b_if.wr = wr; b_if.sel = sel; b_if.wdata = wd;
  endtask

  logic [5:0] ga, gb;
  logic       a_prev, b_prev;

  initial begin
    reset = 1'b1;
    a_lock = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);
    rf_mem[0] = 16'h1111; rf_mem[1] = 16'h2222; rf_mem[2] = 16'h3333; rf_mem[3] = 16'hBEEF;
    m_seg[0]  = 16'h1111; m_seg[1]  = 16'h2222; m_seg[2]  = 16'h3333; m_seg[3]  = 16'hBEEF;
    repeat (3) cyc();
    drive_a(1'b1, 1'b0, 2'd0, 16'h0000);
    #1 chk1("lit_rst_no_ack", a_if.ack, 1'b0);
    cyc();
    reset = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);

    // A writes CS while B reads ES
    cyc();
    drive_a(1'b1, 1'b1, 2'd1, 16'h1234);
    drive_b(1'b1, 1'b0, 2'd0, 16'h0000);
    #1;
    chk1("lit_cs_a_ack", a_if.ack, 1'b1);
    chk1("lit_cs_b_ack", b_if.ack, 1'b0);
    chk1("lit_cs_wr_en", rf_wr_en, 1'b1);
    chk16("lit_cs_wr_sel", {14'd0, rf_wr_sel}, 16'h0001);
    chk16("lit_cs_wr_val", rf_wr_val, 16'h1234);
    cyc();
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    #1;
    chk1("lit_cs_written", cs_written, 1'b1);
    chk1("lit_es_b_ack", b_if.ack, 1'b1);
    cyc();
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);
    #1;
    chk1("lit_es_b_rvalid", b_if.rvalid, 1'b1);
    chk16("lit_es_b_rdata", b_if.rdata, 16'h1111);
    chk1("lit_cs_written_once", cs_written, 1'b0);

    // A reads DS
    cyc();
    drive_a(1'b1, 1'b0, 2'd3, 16'h0000);
    #1;
    chk1("lit_ds_a_ack", a_if.ack, 1'b1);
    chk16("lit_ds_rd_sel", {14'd0, rf_rd_sel}, 16'h0003);
    cyc();
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    #1;
    chk1("lit_ds_rvalid", a_if.rvalid, 1'b1);
    chk16("lit_ds_rdata", a_if.rdata, 16'hBEEF);
    cyc();
    #1;
    chk1("lit_ds_rvalid_off", a_if.rvalid, 1'b0);
    chk16("lit_ds_rdata_held", a_if.rdata, 16'hBEEF);
    chk16("lit_ds_rd_sel_held", {14'd0, rf_rd_sel}, 16'h0003);

    // Starvation: both request continuously
    cyc();
    drive_a(1'b1, 1'b0, 2'd0, 16'h0000);
    drive_b(1'b1, 1'b0, 2'd1, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      #1;
      ga[k] = a_if.ack;
      gb[k] = b_if.ack;
      cyc();
    end
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);
    chk16("lit_starve_b_pattern", {10'd0, gb}, 16'h0010);
    chk16("lit_starve_a_pattern", {10'd0, ga}, 16'h002F);

    // Read-then-write hazard on SS
    cyc();
    drive_a(1'b1, 1'b0, 2'd2, 16'h0000);
    #1 chk1("lit_hz_a_ack", a_if.ack, 1'b1);
    cyc();
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    drive_b(1'b1, 1'b1, 2'd2, 16'h5555);
    #1;
    chk1("lit_hz_b_stalled", b_if.ack, 1'b0);
    chk1("lit_hz_a_rvalid", a_if.rvalid, 1'b1);
    chk16("lit_hz_a_rdata_old", a_if.rdata, 16'h3333);
    cyc();
    #1;
    chk1("lit_hz_b_ack", b_if.ack, 1'b1);
    chk16("lit_hz_wr_val", rf_wr_val, 16'h5555);
    cyc();
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);
    drive_a(1'b1, 1'b0, 2'd2, 16'h0000);
    cyc();
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    #1 chk16("lit_hz_new_ss", a_if.rdata, 16'h5555);

    // Lock: three locked writes, then held idle, then released
    cyc();
    a_lock = 1'b1;
    drive_a(1'b1, 1'b1, 2'd0, 16'hA000);
    drive_b(1'b1, 1'b0, 2'd3, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) a_if.wdata = 16'hA000 + 16'(k);
      if (k == 3) a_if.req = 1'b0;
      if (k == 5) a_lock = 1'b0;
      #1;
      ga[k] = a_if.ack;
      gb[k] = b_if.ack;
      cyc();
    end
    chk16("lit_lock_b_pattern", {10'd0, gb}, 16'h0020);
    chk16("lit_lock_a_pattern", {10'd0, ga}, 16'h0007);
    repeat (4) cyc();
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);

    // Reset asserted the cycle after a B read grant
    cyc();
    drive_b(1'b1, 1'b0, 2'd0, 16'h0000);
    #1 chk1("lit_rr_b_ack", b_if.ack, 1'b1);
    cyc();
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);
    reset = 1'b1;
    #1;
    chk1("lit_rr_b_rvalid", b_if.rvalid, 1'b0);
    chk16("lit_rr_b_rdata", b_if.rdata, 16'h0000);
    chk16("lit_rr_rd_sel", {14'd0, rf_rd_sel}, 16'h0000);
    cyc();
    #1 chk1("lit_rr_b_rvalid_after", b_if.rvalid, 1'b0);
    cyc();
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 2'd1, 16'h0000);
    #1 chk1("lit_post_rst_a_ack", a_if.ack, 1'b1);
    cyc();
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    #1;
    chk1("lit_post_rst_rvalid", a_if.rvalid, 1'b1);
    chk16("lit_post_rst_rdata", a_if.rdata, 16'h1234);

    // Mixed traffic; requests held until acknowledged
    a_prev = 1'b0;
    b_prev = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (!a_if.req || a_prev)
        drive_a(((i * 7) % 5) != 0, (i % 3) == 0, 2'((i * 3) % 4), 16'hC000 + 16'(i));
      if (!b_if.req || b_prev)
        drive_b((i % 4) != 3, (i % 5) == 2, 2'((i + 1) % 4), 16'hD000 + 16'(i));
      a_lock = ((i % 16) >= 9) && ((i % 16) <= 12);
      #1;
      a_prev = a_if.ack;
      b_prev = b_if.ack;
      cyc();
    end
    a_lock = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 16'h0000);
    drive_b(1'b0, 1'b0, 2'd0, 16'h0000);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
